// File: rtl/router_ingress_fifo_if.sv
// router_ingress_fifo_if: groups the producer and consumer signals of the ingress FIFO.
//   din/push/grant : NIN-channel write side (grant is one-hot or zero)
//   pop/dout/empty : show-ahead read side
//   full/almost_full/count/ovf_err/unf_err : occupancy and sticky error status
// Modports: slave (the FIFO), master (producers/consumer driving it).
interface router_ingress_fifo_if #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned NIN   = 8
) ();
  logic [NIN*DW-1:0]        din;
  logic [NIN-1:0]           push;
  logic [NIN-1:0]           grant;
  logic                     pop;
  logic [DW-1:0]            dout;
  logic                     empty;
  logic                     full;
  logic                     almost_full;
  logic [$clog2(DEPTH):0]   count;
  logic                     ovf_err;
  logic                     unf_err;

  modport slave (
    input  din, push, pop,
    output grant, dout, empty, full, almost_full, count, ovf_err, unf_err
  );

  modport master (
    output din, push, pop,
    input  grant, dout, empty, full, almost_full, count, ovf_err, unf_err
  );
endinterface

// File: rtl/router_ingress_fifo.sv
// router_ingress_fifo: arbitrated multi-input ingress queue with a DEPTH-entry circular buffer
// and a show-ahead pop interface.
// Ports:
//   clk    : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : router_ingress_fifo_if.slave (din, push, grant, pop, dout, empty, full,
//            almost_full, count, ovf_err, unf_err)
// Configuration macro ROUTER_FIFO_RR_EN: defined selects round-robin arbitration starting at
// rr_ptr; undefined selects fixed priority (lowest channel index wins).
module router_ingress_fifo #(
  parameter int unsigned DW       = 32,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NIN      = 8,
  parameter int unsigned AFULL_TH = DEPTH - 2
) (
  input logic                  clk,
  input logic                  resetn,
  router_ingress_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned IW = (NIN > 1) ? $clog2(NIN) : 1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic          full, empty;
  logic          wr_en, rd_en;
  logic [IW-1:0] winner;
  logic [NIN-1:0] grant;
  int unsigned   idx;

`ifdef ROUTER_FIFO_RR_EN
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
`endif

  // Status is decoded from count only; pointer equality is ambiguous at full/empty.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Arbiter: depends only on push, full and rr_ptr, never on pop.
  always_comb begin
    wr_en  = 1'b0;
    winner = '0;
    grant  = '0;
    idx    = 0;
    if (!full) begin
      for (int unsigned i = 0; i < NIN; i++) begin
`ifdef ROUTER_FIFO_RR_EN
        idx = (int'(rr_ptr_q) + i) % NIN;
`else
        idx = i;
`endif
        if (!wr_en && bus.push[idx]) begin
          wr_en  = 1'b1;
          winner = IW'(idx);
        end
      end
    end
    if (wr_en) grant[winner] = 1'b1;
  end

  assign rd_en = bus.pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    // Overflow: someone requested but the buffer refused everything because it was full.
    if ((|bus.push) && full) ovf_d = 1'b1;
    if (bus.pop && empty)    unf_d = 1'b1;
  end

`ifdef ROUTER_FIFO_RR_EN
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (wr_en) rr_ptr_d = (winner == IW'(NIN - 1)) ? '0 : winner + IW'(1);
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
`ifdef ROUTER_FIFO_RR_EN
      rr_ptr_q <= '0;
`endif
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
`ifdef ROUTER_FIFO_RR_EN
      rr_ptr_q <= rr_ptr_d;
`endif
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= bus.din[winner*DW +: DW];
  end

  assign bus.grant       = grant;
  assign bus.dout        = mem[rd_ptr_q];
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.almost_full = (count_q >= CW'(AFULL_TH));
  assign bus.count       = count_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.unf_err     = unf_q;
endmodule

// File: tb/tb_router_ingress_fifo.sv
module tb_router_ingress_fifo;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NIN   = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  router_ingress_fifo_if #(.DW(DW), .DEPTH(DEPTH), .NIN(NIN)) bus ();

  router_ingress_fifo #(.DW(DW), .DEPTH(DEPTH), .NIN(NIN)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  typedef struct {
    logic [NIN-1:0] push;
    logic [DW-1:0]  data;
    logic           pop;
    logic [NIN-1:0] exp_grant;
    logic           chk_dout;
    logic [DW-1:0]  exp_dout;
    logic [4:0]     exp_count;
    logic           exp_full;
    logic           exp_afull;
    logic           exp_empty;
  } vec_t;

  vec_t vecs[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    bus.push = '0;
    bus.pop  = 1'b0;
    bus.din  = '0;
    resetn   = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
  endtask

  task automatic push_ch(input int ch, input logic [DW-1:0] d);
    bus.push     = '0;
    bus.push[ch] = 1'b1;
    bus.din      = '0;
    bus.din[ch*DW +: DW] = d;
    tick();
  endtask

  initial begin
    logic [NIN-1:0] exp_g;

    // Single-channel fill then drain on channel 3.
    for (int n = 0; n < 16; n++) begin
      vecs[n] = '{push: 8'h08, data: 32'h100 + n, pop: 1'b0, exp_grant: 8'h08,
                  chk_dout: 1'b0, exp_dout: '0, exp_count: 5'(n + 1),
                  exp_full: (n == 15), exp_afull: (n + 1 >= 14), exp_empty: 1'b0};
      vecs[16 + n] = '{push: 8'h00, data: '0, pop: 1'b1, exp_grant: 8'h00,
                       chk_dout: 1'b1, exp_dout: 32'h100 + n, exp_count: 5'(15 - n),
                       exp_full: 1'b0, exp_afull: (15 - n >= 14), exp_empty: (n == 15)};
    end

    do_reset();
    #1;
    check("reset_empty", 32'(bus.empty), 32'd1);
    check("reset_full", 32'(bus.full), 32'd0);
    check("reset_afull", 32'(bus.almost_full), 32'd0);
    check("reset_count", 32'(bus.count), 32'd0);
    check("reset_grant", 32'(bus.grant), 32'd0);
    check("reset_ovf", 32'(bus.ovf_err), 32'd0);
    check("reset_unf", 32'(bus.unf_err), 32'd0);

    for (int i = 0; i < 32; i++) begin
      bus.push = vecs[i].push;
      bus.din  = '0;
      bus.din[3*DW +: DW] = vecs[i].data;
      bus.pop  = vecs[i].pop;
      #1;
      check($sformatf("vec%0d_grant", i), 32'(bus.grant), 32'(vecs[i].exp_grant));
      if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      tick();
      check($sformatf("vec%0d_count", i), 32'(bus.count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_full", i), 32'(bus.full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_afull", i), 32'(bus.almost_full), 32'(vecs[i].exp_afull));
      check($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
    end
    bus.pop = 1'b0;

    // Pointers wrapped: a fresh word must appear at the head the cycle after it is written.
    push_ch(4, 32'hCAFE_0001);
    bus.push = '0;
    #1;
    check("wrap_dout", bus.dout, 32'hCAFE_0001);
    check("wrap_empty", 32'(bus.empty), 32'd0);

    // Contention on channels 0, 2, 5.
    do_reset();
    bus.push = 8'b0010_0101;
    bus.din  = '0;
    for (int i = 0; i < NIN; i++) bus.din[i*DW +: DW] = 32'hA0 + i;
    for (int i = 0; i < 6; i++) begin
      #1;
`ifdef ROUTER_FIFO_RR_EN
      case (i % 3)
        0:       exp_g = 8'h01;
        1:       exp_g = 8'h04;
        default: exp_g = 8'h20;
      endcase
`else
      exp_g = 8'h01;
`endif
      check($sformatf("contend%0d_grant", i), 32'(bus.grant), 32'(exp_g));
      tick();
    end
    bus.push = '0;
    #1;
    check("contend_count", 32'(bus.count), 32'd6);

    // Errors: underflow, then overflow while full; both sticky.
    do_reset();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    #1;
    check("unf_set", 32'(bus.unf_err), 32'd1);
    check("unf_count", 32'(bus.count), 32'd0);
    for (int n = 0; n < 16; n++) push_ch(0, 32'h200 + n);
    bus.push = '0;
    #1;
    check("fill_full", 32'(bus.full), 32'd1);
    check("ovf_before", 32'(bus.ovf_err), 32'd0);
    bus.push = 8'h80;
    #1;
    check("ovf_grant", 32'(bus.grant), 32'd0);
    tick();
    tick();
    bus.push = '0;
    #1;
    check("ovf_set", 32'(bus.ovf_err), 32'd1);
    check("ovf_count", 32'(bus.count), 32'd16);
    repeat (3) tick();
    #1;
    check("ovf_sticky", 32'(bus.ovf_err), 32'd1);
    check("unf_sticky", 32'(bus.unf_err), 32'd1);

    // Full with simultaneous pop: pop wins this cycle, push granted the next.
    bus.push = 8'h02;
    bus.din  = '0;
    bus.din[1*DW +: DW] = 32'hBEEF;
    bus.pop  = 1'b1;
    #1;
    check("fullpop_grant", 32'(bus.grant), 32'd0);
    check("fullpop_dout", bus.dout, 32'h200);
    tick();
    bus.pop = 1'b0;
    #1;
    check("fullpop_count", 32'(bus.count), 32'd15);
    check("fullpop_grant_next", 32'(bus.grant), 32'h02);
    tick();
    bus.push = '0;
    #1;
    check("fullpop_count_next", 32'(bus.count), 32'd16);
    check("fullpop_head", bus.dout, 32'h201);

    // Asynchronous reset mid-operation at count 9.
    do_reset();
    for (int n = 0; n < 9; n++) push_ch(6, 32'h300 + n);
    bus.push = '0;
    bus.pop  = 1'b1;
    #1;
    check("pre_async_count", 32'(bus.count), 32'd9);
    resetn = 1'b0;
    #1;
    check("async_count", 32'(bus.count), 32'd0);
    check("async_empty", 32'(bus.empty), 32'd1);
    check("async_grant", 32'(bus.grant), 32'd0);
    bus.pop = 1'b0;
    #2;
    resetn = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end
endmodule
